byte_frame_sender: RTL
======================

BYTE_FRAME_SENDER -- requirements
Module: byte_frame_sender

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max cycles spent in WAIT before abort (range 1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 wr_en  in  1  load strobe for frame buffer.
REQ-005 wr_addr  in  3  buffer slot index 0..7.
REQ-006 wr_data  in  8  unsigned byte to store.
REQ-007 send  in  1  request to transmit stored frame.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 start_o  out  1  frame-start strobe to averager.
REQ-010 data_o  out  8  streamed byte to averager.
REQ-011 w_i  in  8  averager result.
REQ-012 done_i  in  1  averager result-valid strobe.
REQ-013 result  out  8  last captured w_i.
REQ-014 result_vld  out  1  one-cycle pulse on capture.
REQ-015 timeout  out  1  sticky abort flag.

Function
REQ-016 Buffer SHALL be 8 x 8-bit registers; in IDLE with wr_en=1, slot wr_addr SHALL take wr_data at the clock edge.
REQ-017 wr_en outside IDLE SHALL be ignored; buffer contents unchanged.
REQ-018 FSM states SHALL be IDLE, STREAM, WAIT.
REQ-019 IDLE -> STREAM when send=1; the 3-bit index SHALL clear to 0 on that edge.
REQ-020 In STREAM, data_o SHALL equal buf[index]; index SHALL increment each cycle; start_o SHALL be 1 only while index=0.
REQ-021 STREAM SHALL last exactly 8 cycles, bytes 0..7 in order; after index=7, go to WAIT.
REQ-022 In WAIT, done_i=1 SHALL load result<=w_i, pulse result_vld for 1 cycle, and return to IDLE.
REQ-023 done_i in IDLE or STREAM SHALL be ignored.
REQ-024 WAIT cycle counter (8-bit) SHALL clear on entry; if it reaches TIMEOUT_CYC without done_i, FSM SHALL go to IDLE, set timeout=1, leave result unchanged.
REQ-025 done_i on the same cycle the count reaches TIMEOUT_CYC SHALL win: capture occurs, timeout not set.
REQ-026 timeout SHALL clear on the next accepted send.
REQ-027 send while busy=1 SHALL be ignored (not queued).
REQ-028 data_o SHALL be 0 outside STREAM; start_o SHALL be 0 outside STREAM.
REQ-029 Latency: send edge to first data_o = 1 cycle; last byte to WAIT = 1 cycle.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, index=0, wait counter=0, busy=0, start_o=0, data_o=0, result=0, result_vld=0, timeout=0, and all buffer slots=0.
REQ-031 rst asserted mid-STREAM or mid-WAIT SHALL abort with no result_vld pulse; after release, module SHALL accept send on the first edge.

Configuration
REQ-032 Macro FRAME_CHECK_EN SHALL gate a self-check feature.
REQ-033 With FRAME_CHECK_EN defined: during STREAM, running min/max SHALL be tracked; expected = (min+max)>>1 computed with a 9-bit sum; on capture, output mismatch (1 bit, sticky until next send, reset 0) SHALL set if w_i != expected.
REQ-034 Without FRAME_CHECK_EN: no mismatch port, no min/max logic; all other behaviour identical.

Verification
REQ-035 Load 15,76,218,38,41,241,112,72 to slots 0..7, send -> data_o sequence matches for 8 cycles, start_o high only with 15; done_i with w_i=128 -> result=128, result_vld 1 cycle.
REQ-036 FRAME_CHECK_EN, same frame, w_i=127 -> mismatch=1; with w_i=128 -> mismatch=0.
REQ-037 send at byte 3 of STREAM and wr_en during WAIT -> no restart, buffer unchanged on next frame.
REQ-038 TIMEOUT_CYC=4, no done_i -> return to IDLE after 4 WAIT cycles, timeout=1, result unchanged; next send clears timeout.
REQ-039 rst pulse during WAIT, then done_i -> no result_vld, all outputs 0, buffer all 0.
REQ-040 Frame of all 255 under FRAME_CHECK_EN, w_i=255 -> no overflow, mismatch=0.

Source files
------------

// File: rtl/byte_frame_sender.sv
// byte_frame_sender: stores an 8-byte frame and streams it to an external averager.
// When the averager's result arrives, the sender captures it. If no result comes
// back in time, it aborts with a sticky timeout flag.
//
// Optional feature: define FRAME_CHECK_EN to enable the frame self-check. In that
// build the sender tracks the running min/max of the streamed bytes. It then
// compares the captured result against (min+max)>>1 and reports the outcome on a
// sticky 'mismatch' output.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   wr_en/wr_addr/    frame buffer write port, accepted only while idle
//   wr_data
//   send              start streaming the stored frame (ignored while busy)
//   busy              high whenever not idle
//   start_o, data_o   frame-start strobe and streamed byte to the averager
//   w_i, done_i       averager result and its valid strobe
//   result,           last captured result and its one-cycle capture pulse
//   result_vld
//   mismatch          (FRAME_CHECK_EN only) captured result differs from (min+max)>>1
//   timeout           sticky abort flag, cleared by the next accepted send
module byte_frame_sender #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       send,
  output logic       busy,
  output logic       start_o,
  output logic [7:0] data_o,
  input  logic [7:0] w_i,
  input  logic       done_i,
  output logic [7:0] result,
  output logic       result_vld,
`ifdef FRAME_CHECK_EN
  output logic       mismatch,
`endif
  output logic       timeout
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StWait
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       result_vld_q, result_vld_d;
  logic       timeout_q, timeout_d;
  logic [7:0] frame_q [8];
  logic       frame_we;
  logic       send_acc;
  logic       capture;

  // Writes are honoured only while idle so a frame cannot change mid-transfer.
  assign frame_we = wr_en && (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        frame_q[i] <= 8'd0;
      end
    end else if (frame_we) begin
      frame_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    timeout_d    = timeout_q;
    send_acc     = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (send) begin
          send_acc  = 1'b1;
          state_d   = StStream;
          idx_d     = 3'd0;
          timeout_d = 1'b0;
        end
      end
      StStream: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving on the final counted cycle still wins over the abort.
        if (done_i) begin
          capture      = 1'b1;
          result_d     = w_i;
          result_vld_d = 1'b1;
          state_d      = StIdle;
        end else if (cnt_d == TimeoutVal) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      cnt_q        <= 8'd0;
      result_q     <= 8'd0;
      result_vld_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign start_o    = (state_q == StStream) && (idx_q == 3'd0);
  assign data_o     = (state_q == StStream) ? frame_q[idx_q] : 8'd0;
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign timeout    = timeout_q;

`ifdef FRAME_CHECK_EN
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;
  logic [7:0] mid;
  logic       mismatch_q, mismatch_d;
  logic [7:0] cur_byte;

  assign cur_byte = frame_q[idx_q];
  // 9-bit sum so an all-255 frame does not wrap before the halving.
  assign mid      = 8'(({1'b0, min_q} + {1'b0, max_q}) >> 1);

  always_comb begin
    min_d      = min_q;
    max_d      = max_q;
    mismatch_d = mismatch_q;
    if (state_q == StStream) begin
      // The first byte seeds both trackers; later bytes refine them.
      if (idx_q == 3'd0) begin
        min_d = cur_byte;
        max_d = cur_byte;
      end else begin
        if (cur_byte < min_q) min_d = cur_byte;
        if (cur_byte > max_q) max_d = cur_byte;
      end
    end
    if (send_acc) begin
      mismatch_d = 1'b0;
    end else if (capture && (w_i != mid)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q      <= 8'd0;
      max_q      <= 8'd0;
      mismatch_q <= 1'b0;
    end else begin
      min_q      <= min_d;
      max_q      <= max_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule
